// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths, constants and the FIFO entry type for the
//               register-file write-side front end.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int NREG   = 1 << REG_W;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of wb_entry_t for long-unit results.
//               DEPTH must be a power of two so pointers wrap naturally.
//               Pushes when full and pops when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file write port arbiter. Pipeline writebacks own
//               the port; long-unit results queue in a FIFO and drain in
//               idle cycles. A busy scoreboard stalls decode on registers
//               with a long-latency write outstanding.
//               Optional macro WB_LU_BYPASS_EN: a long-unit result arriving
//               with an empty FIFO and no pipeline write skips the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pipe_wen,
  input  logic [REG_W-1:0]       pipe_waddr,
  input  logic [DATA_W-1:0]      pipe_wdata,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [REG_W-1:0]       lu_waddr,
  input  logic [DATA_W-1:0]      lu_wdata,
  input  logic                   issue_valid,
  input  logic [REG_W-1:0]       issue_waddr,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rt,
  input  logic [REG_W-1:0]       id_rd,
  output logic                   hazard_stall,
  output logic                   RegWrite,
  output logic [REG_W-1:0]       Write_register,
  output logic [DATA_W-1:0]      Write_data,
  output logic [$clog2(DEPTH):0] pending
);

  logic            pipe_eff;
  logic            lu_keep;
  logic            bypass;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  wb_entry_t       lu_entry;
  wb_entry_t       head;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Writes to $zero are dropped outright; they never claim the port.
  assign pipe_eff = pipe_wen && (pipe_waddr != ZERO_REG);
  assign lu_ready = !fifo_full;
  // A handshake to $zero completes but the result is discarded.
  assign lu_keep  = lu_valid && lu_ready && (lu_waddr != ZERO_REG);

`ifdef WB_LU_BYPASS_EN
  assign bypass = fifo_empty && !pipe_eff && lu_keep;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = lu_keep && !bypass;
  assign fifo_pop  = !pipe_eff && !fifo_empty;
  assign lu_entry  = '{waddr: lu_waddr, wdata: lu_wdata};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (lu_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  // Registered write port: pipeline first, then FIFO head, then bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
    end else if (pipe_eff) begin
      RegWrite       <= 1'b1;
      Write_register <= pipe_waddr;
      Write_data     <= pipe_wdata;
    end else if (fifo_pop) begin
      RegWrite       <= 1'b1;
      Write_register <= head.waddr;
      Write_data     <= head.wdata;
    end else if (bypass) begin
      RegWrite       <= 1'b1;
      Write_register <= lu_waddr;
      Write_data     <= lu_wdata;
    end else begin
      RegWrite       <= 1'b0;
    end
  end

  // Next busy vector: clears from retiring long results, then issue sets win.
  always_comb begin
    busy_nxt = busy;
    if (fifo_pop) busy_nxt[head.waddr] = 1'b0;
    if (bypass)   busy_nxt[lu_waddr]   = 1'b0;
    if (issue_valid && (issue_waddr != ZERO_REG)) busy_nxt[issue_waddr] = 1'b1;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // The id_rd term blocks a WAW against a still-pending long result.
  assign hazard_stall = (busy[id_rs] && (id_rs != ZERO_REG)) ||
                        (busy[id_rt] && (id_rt != ZERO_REG)) ||
                        (busy[id_rd] && (id_rd != ZERO_REG));

endmodule
`default_nettype wire
